ttt_game_ctrl: RTL

//  Sequences a 3x3 board of nine TCell storage cells through a tic-tac-toe game.
//  - Accepts move requests, validates them and alternates turns.
//  - Drives the one-hot cell set strobes and clears the board.
//  - Detects win/draw from the cells' valid/symbol outputs.

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/ttt_line_check.sv | 31 +++
 rtl/ttt_game_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Holds the FSM state encoding, the symbol values and the table of the eight winning lines.
package ttt_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_WAIT,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic SYM_X = 1'b0;
    localparam logic SYM_O = 1'b1;

    localparam int NCELLS = 9;
    localparam int NLINES = 8;

    // Three rows, three columns and two diagonals, as row-major cell indices.
    localparam logic [3:0] WIN_LINES [NLINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational board evaluator: reports a completed line, that line's symbol,
// and whether every cell is occupied.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [NCELLS-1:0] cell_valid,
    input  logic [NCELLS-1:0] cell_symbol,
    output logic              win,
    output logic              win_sym,
    output logic              full
);

    always_comb begin
        win     = 1'b0;
        win_sym = SYM_X;
        for (int i = 0; i < NLINES; i++) begin
            if (!win
                && cell_valid[WIN_LINES[i][0]]
                && cell_valid[WIN_LINES[i][1]]
                && cell_valid[WIN_LINES[i][2]]
                && (cell_symbol[WIN_LINES[i][0]] == cell_symbol[WIN_LINES[i][1]])
                && (cell_symbol[WIN_LINES[i][1]] == cell_symbol[WIN_LINES[i][2]])) begin
                win     = 1'b1;
                win_sym = cell_symbol[WIN_LINES[i][0]];
            end
        end
    end

    assign full = &cell_valid;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: validates moves, strobes the cell array, alternates turns
// and latches the game result until the board is cleared.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_SYM = SYM_X,
    parameter bit   ALT_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              move_req,
    input  logic [3:0]        move_pos,
    input  logic [NCELLS-1:0] cell_valid,
    input  logic [NCELLS-1:0] cell_symbol,
    output logic [NCELLS-1:0] cell_set,
    output logic              cell_reset,
    output logic              set_symbol,
    output logic              turn,
    output logic              move_rdy,
    output logic              move_ack,
    output logic              move_err,
    output logic              game_over,
    output logic              winner_vld,
    output logic              winner,
    output logic              draw
);

    state_t            state;
    logic              starter;
    logic              next_starter;
    logic [NCELLS-1:0] set_q;
    logic [15:0]       occ_ext;
    logic              pos_bad;
    logic              win;
    logic              win_sym;
    logic              full;

    ttt_line_check u_chk (
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .win         (win),
        .win_sym     (win_sym),
        .full        (full)
    );

    assign occ_ext      = {{(16-NCELLS){1'b0}}, cell_valid};
    assign pos_bad      = (move_pos > 4'(NCELLS-1)) || occ_ext[move_pos];
    assign next_starter = ALT_START ? ~starter : FIRST_SYM;
    assign set_symbol   = turn;

    // A clear request landing in the WRITE cycle must suppress the strobe at once,
    // so the registered one-hot is gated here rather than one cycle later.
    assign cell_set = (reset || new_game) ? '0 : set_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            starter    <= FIRST_SYM;
            turn       <= FIRST_SYM;
            set_q      <= '0;
            cell_reset <= 1'b1;
            move_rdy   <= 1'b0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
            game_over  <= 1'b0;
            winner_vld <= 1'b0;
            winner     <= 1'b0;
            draw       <= 1'b0;
        end else begin
            set_q    <= '0;
            move_ack <= 1'b0;
            move_err <= 1'b0;
            if (new_game) begin
                state      <= ST_CLEAR;
                cell_reset <= 1'b1;
                move_rdy   <= 1'b0;
                game_over  <= 1'b0;
                winner_vld <= 1'b0;
                winner     <= 1'b0;
                draw       <= 1'b0;
                // Holding new_game keeps the board in CLEAR; the starter flips only on entry.
                if (state != ST_CLEAR) begin
                    starter <= next_starter;
                    turn    <= next_starter;
                end
            end else begin
                case (state)
                    ST_CLEAR: begin
                        cell_reset <= 1'b0;
                        move_rdy   <= 1'b1;
                        game_over  <= 1'b0;
                        winner_vld <= 1'b0;
                        winner     <= 1'b0;
                        draw       <= 1'b0;
                        state      <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (move_req) begin
                            if (pos_bad) begin
                                move_err <= 1'b1;
                            end else begin
                                set_q    <= {{(NCELLS-1){1'b0}}, 1'b1} << move_pos;
                                move_rdy <= 1'b0;
                                state    <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (win) begin
                            winner_vld <= 1'b1;
                            winner     <= win_sym;
                            game_over  <= 1'b1;
                            state      <= ST_DONE;
                        end else if (full) begin
                            draw      <= 1'b1;
                            game_over <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            move_ack <= 1'b1;
                            turn     <= ~turn;
                            move_rdy <= 1'b1;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state      <= ST_CLEAR;
                        cell_reset <= 1'b1;
                        move_rdy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
